sysid_check_sequencer: RTL and testbench
========================================

Name: sysid_check_sequencer

Overview:
- Sequences reads of the system-ID slave (address 0 = ID word, address 1 = build timestamp) after every reset and on demand.
- Compares the values read against build-time expected values and retries a bounded number of times on mismatch.
- Reports pass/fail status to the board-level status logic.
- After the check completes, arbitrates the same slave to a CPU-side Avalon-MM read port, so one ID slave serves both boot check and software.

Parameters:
- EXP_ID, 0, expected 32-bit ID word at slave address 0
- EXP_TIMESTAMP, 32'h5BA8CA7E, expected 32-bit timestamp at slave address 1
- CHECK_TS, 1, 1 = timestamp must match; 0 = timestamp read and captured but not compared
- READ_WAIT, 1, cycles sid_address is held before readdata is sampled (0..7)
- MAX_RETRY, 3, retries after the first failed attempt (0..15)
- RETRY_GAP, 8, idle cycles between attempts (1..255)

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- recheck  in  1  one-cycle pulse; re-runs the check
- sid_address  out  1  address to system-ID slave
- sid_readdata  in  32  readdata from system-ID slave, combinational on sid_address
- cpu_address  in  1  CPU read address
- cpu_read  in  1  CPU read request
- cpu_waitrequest  out  1  1 = CPU request not accepted this cycle
- cpu_readdata  out  32  registered read result
- cpu_readdatavalid  out  1  one-cycle pulse with cpu_readdata
- id_value  out  32  captured ID
- ts_value  out  32  captured timestamp
- done  out  1  check finished
- pass  out  1  check passed
- fail  out  1  check failed after all retries
- retry_count  out  4  retries consumed

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous, active-high, and dominant in any state, including mid-read or mid-gap.
- Reset values:
  - sid_address = 0, cpu_waitrequest = 1.
  - cpu_readdata, cpu_readdatavalid, id_value, ts_value, done, pass, fail, retry_count all 0.
  - State RD_ID, wait counter 0, recheck-pending flag 0.
- RD_ID:
  - Drive sid_address = 0 and count wait_cnt 0..READ_WAIT.
  - When wait_cnt == READ_WAIT: id_value <= sid_readdata, clear wait_cnt, go to RD_TS.
  - Total of READ_WAIT+1 cycles.
- RD_TS:
  - Same as RD_ID with sid_address = 1, capturing ts_value.
  - Then go to COMPARE.
- COMPARE (1 cycle):
  - ok = (id_value == EXP_ID) && (CHECK_TS == 0 || ts_value == EXP_TIMESTAMP).
  - If ok: done <= 1, pass <= 1, go to DONE.
  - Else if retry_count < MAX_RETRY: retry_count++, go to GAP.
  - Else: done <= 1, fail <= 1, go to DONE.
- GAP: idle RETRY_GAP cycles with sid_address = 0, then go to RD_ID.
- Timing: first done rises on clock edge number 2*(READ_WAIT+1)+1 after reset deasserts (5 at defaults).
- Exclusivity: pass and fail are never both 1. done = pass | fail.
- cpu_waitrequest:
  - Registered output.
  - 0 only while in DONE; 1 in every other state, including the cycle DONE is left.
- CPU read:
  - In DONE, cpu_read = 1 is accepted (waitrequest is 0): latch cpu_address, go to CPU_RD.
  - CPU_RD drives sid_address = latched address for READ_WAIT+1 cycles.
  - On the last cycle, cpu_readdata <= sid_readdata; cpu_readdatavalid pulses 1 on the following cycle, coinciding with the return to DONE.
  - cpu_readdata holds its value until the next read.
  - Back-to-back reads are allowed: a new accept can occur on the first DONE cycle.
- recheck in DONE without cpu_read:
  - Clear done, pass, fail and retry_count next cycle; go to RD_ID.
  - id_value and ts_value keep their old values until overwritten.
- recheck together with an accepted cpu_read, or during CPU_RD:
  - The CPU read completes first.
  - recheck is held in the pending flag and taken on the first DONE cycle; no CPU read is accepted on that cycle.
- recheck during RD_ID, RD_TS, COMPARE or GAP: ignored, since a check is already running.
- CPU reads before done: not accepted, cpu_waitrequest stays 1. The requester stalls, with no error response.
- Arithmetic limits:
  - retry_count saturates at MAX_RETRY and never wraps.
  - wait_cnt is 3 bits; the gap counter is 8 bits.

Test Plan:
- Pass path: reset for 3 cycles, slave returns 0 / 32'h5BA8CA7E -> done = pass = 1 on edge 5, fail = 0, retry_count = 0, id_value = 0, ts_value = 32'h5BA8CA7E.
- Mismatch path: slave returns timestamp 32'h5BA8CA7F always -> 4 attempts separated by 8-cycle gaps, then fail = 1, retry_count = 3, pass = 0. Repeat with CHECK_TS = 0 -> pass = 1 on the first attempt.
- Recovery: slave wrong on attempts 1-2 and correct on attempt 3 -> pass = 1, retry_count = 2.
- CPU reads in DONE: read address 1 then address 0 back-to-back -> each cpu_readdatavalid pulse arrives READ_WAIT+2 cycles after accept with 32'h5BA8CA7E then 0; cpu_waitrequest = 1 during CPU_RD. A read issued before done stalls until done.
- Simultaneous events: recheck pulse in the same cycle as cpu_read in DONE -> CPU data returned first, then done/pass clear and the check re-runs; a recheck pulse during GAP -> no effect.
- Reset mid-operation: assert reset for 1 cycle during RD_TS and again during CPU_RD -> all outputs return to reset values, cpu_readdatavalid never pulses, and the check restarts from RD_ID.

Source files
------------

// File: rtl/sysid_check_sequencer.sv
// sysid_check_sequencer
// Reads the system-ID slave (ID word, then build timestamp) after reset and on
// demand, compares against build-time constants with bounded retries, reports
// pass/fail, and then lends the same slave to a CPU-side Avalon-MM read port.
module sysid_check_sequencer #(
  parameter logic [31:0] EXP_ID        = 32'h0000_0000,
  parameter logic [31:0] EXP_TIMESTAMP = 32'h5BA8_CA7E,
  parameter bit          CHECK_TS      = 1'b1,
  parameter int unsigned READ_WAIT     = 1,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned RETRY_GAP     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        recheck,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  input  logic        cpu_address,
  input  logic        cpu_read,
  output logic        cpu_waitrequest,
  output logic [31:0] cpu_readdata,
  output logic        cpu_readdatavalid,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [3:0]  retry_count
);

  localparam logic [2:0] ST_RD_ID   = 3'd0;
  localparam logic [2:0] ST_RD_TS   = 3'd1;
  localparam logic [2:0] ST_COMPARE = 3'd2;
  localparam logic [2:0] ST_GAP     = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_CPU_RD  = 3'd5;

  localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT);
  localparam logic [7:0] GAP_LAST  = 8'(RETRY_GAP - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  logic [2:0]  state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        pending_q, pending_d;
  logic        cpu_addr_q, cpu_addr_d;
  logic        waitreq_q, waitreq_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_valid_q, cpu_valid_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [3:0]  retry_q, retry_d;
  logic        match;

  // Captured values match the build constants (timestamp optional)
  always_comb begin
    match = (id_q == EXP_ID) && (!CHECK_TS || (ts_q == EXP_TIMESTAMP));
  end

  // Slave address follows the active reader: timestamp phase or latched CPU address
  always_comb begin
    sid_address = (state_q == ST_RD_TS) || ((state_q == ST_CPU_RD) && cpu_addr_q);
  end

  // Next-state and datapath logic for the check sequence and CPU arbitration
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pending_d   = pending_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_valid_d = 1'b0;
    id_d        = id_q;
    ts_d        = ts_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    retry_d     = retry_q;

    case (state_q)
      ST_RD_ID: begin
        if (wait_cnt_q == WAIT_LAST) begin
          id_d       = sid_readdata;
          wait_cnt_d = 3'd0;
          state_d    = ST_RD_TS;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ST_RD_TS: begin
        if (wait_cnt_q == WAIT_LAST) begin
          ts_d       = sid_readdata;
          wait_cnt_d = 3'd0;
          state_d    = ST_COMPARE;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ST_COMPARE: begin
        if (match) begin
          pass_d  = 1'b1;
          state_d = ST_DONE;
        end else if (retry_q < RETRY_MAX) begin
          retry_d   = retry_q + 4'd1;
          gap_cnt_d = 8'd0;
          state_d   = ST_GAP;
        end else begin
          fail_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d  = 8'd0;
          wait_cnt_d = 3'd0;
          state_d    = ST_RD_ID;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        if (pending_q) begin
          pending_d  = 1'b0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          retry_d    = 4'd0;
          wait_cnt_d = 3'd0;
          state_d    = ST_RD_ID;
        end else if (cpu_read) begin
          cpu_addr_d = cpu_address;
          wait_cnt_d = 3'd0;
          state_d    = ST_CPU_RD;
          if (recheck) begin
            pending_d = 1'b1;
          end
        end else if (recheck) begin
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          retry_d    = 4'd0;
          wait_cnt_d = 3'd0;
          state_d    = ST_RD_ID;
        end
      end
      ST_CPU_RD: begin
        if (recheck) begin
          pending_d = 1'b1;
        end
        if (wait_cnt_q == WAIT_LAST) begin
          cpu_rdata_d = sid_readdata;
          cpu_valid_d = 1'b1;
          wait_cnt_d  = 3'd0;
          state_d     = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      default: begin
        wait_cnt_d = 3'd0;
        state_d    = ST_RD_ID;
      end
    endcase

    // A DONE cycle that is about to launch a pending recheck refuses CPU reads
    waitreq_d = !((state_d == ST_DONE) && !pending_d);
  end

  // State and output registers with synchronous dominant reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RD_ID;
      wait_cnt_q  <= 3'd0;
      gap_cnt_q   <= 8'd0;
      pending_q   <= 1'b0;
      cpu_addr_q  <= 1'b0;
      waitreq_q   <= 1'b1;
      cpu_rdata_q <= 32'd0;
      cpu_valid_q <= 1'b0;
      id_q        <= 32'd0;
      ts_q        <= 32'd0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      retry_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pending_q   <= pending_d;
      cpu_addr_q  <= cpu_addr_d;
      waitreq_q   <= waitreq_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_valid_q <= cpu_valid_d;
      id_q        <= id_d;
      ts_q        <= ts_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      retry_q     <= retry_d;
    end
  end

  assign cpu_waitrequest   = waitreq_q;
  assign cpu_readdata      = cpu_rdata_q;
  assign cpu_readdatavalid = cpu_valid_q;
  assign id_value          = id_q;
  assign ts_value          = ts_q;
  assign pass              = pass_q;
  assign fail              = fail_q;
  assign done              = pass_q | fail_q;
  assign retry_count       = retry_q;

endmodule

// File: tb/tb_sysid_check_sequencer.sv
// Testbench for sysid_check_sequencer: directed scenarios with literal
// expectations plus a timeline model checked against the DUT every cycle.
module tb_sysid_check_sequencer;

  localparam int RW   = 1;
  localparam int MAXR = 3;
  localparam int GAP  = 8;
  localparam int L    = RW + 1;          // cycles per slave read
  localparam int P    = 2 * L + 1 + GAP; // cycles per check attempt

  localparam logic [31:0] GOOD_ID = 32'h0000_0000;
  localparam logic [31:0] GOOD_TS = 32'h5BA8_CA7E;
  localparam logic [31:0] BAD_TS  = 32'h5BA8_CA7F;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        recheck = 1'b0;
  logic        cpu_address = 1'b0;
  logic        cpu_read = 1'b0;
  logic        sid_address;
  logic [31:0] sid_readdata;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;
  logic [31:0] id_value, ts_value;
  logic        done, pass, fail;
  logic [3:0]  retry_count;

  logic        sid2_address;
  logic [31:0] sid2_readdata;
  logic        cpu2_waitrequest;
  logic [31:0] cpu2_readdata;
  logic        cpu2_readdatavalid;
  logic [31:0] id2_value, ts2_value;
  logic        done2, pass2, fail2;
  logic [3:0]  retry2_count;

  int n_checks = 0;
  int n_fail   = 0;
  int bad_attempts = 0;

  // Model state: timeline of the running check, or CPU-service bookkeeping
  bit          m_init = 1'b0;
  bit          m_checking = 1'b1;
  int          m_u = 0;
  int          m_retries = 0;
  bit          m_pass = 1'b0, m_fail = 1'b0;
  logic [31:0] m_id = '0, m_ts = '0, m_rdata = '0, m_pend_data = '0;
  bit          m_valid = 1'b0;
  int          m_busy = 0;
  bit          m_pending = 1'b0;
  bit          m_addr = 1'b0;

  always #5 clock = ~clock;

  // Slave: timestamp is wrong for the first bad_attempts attempts of a check
  assign sid_readdata  = sid_address ? ((m_retries < bad_attempts) ? BAD_TS : GOOD_TS) : GOOD_ID;
  assign sid2_readdata = sid2_address ? BAD_TS : GOOD_ID;

  sysid_check_sequencer dut (
    .clock(clock), .reset(reset), .recheck(recheck),
    .sid_address(sid_address), .sid_readdata(sid_readdata),
    .cpu_address(cpu_address), .cpu_read(cpu_read),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid),
    .id_value(id_value), .ts_value(ts_value),
    .done(done), .pass(pass), .fail(fail), .retry_count(retry_count)
  );

  sysid_check_sequencer #(.CHECK_TS(1'b0)) dut_nots (
    .clock(clock), .reset(reset), .recheck(1'b0),
    .sid_address(sid2_address), .sid_readdata(sid2_readdata),
    .cpu_address(1'b0), .cpu_read(1'b0),
    .cpu_waitrequest(cpu2_waitrequest), .cpu_readdata(cpu2_readdata),
    .cpu_readdatavalid(cpu2_readdatavalid),
    .id_value(id2_value), .ts_value(ts2_value),
    .done(done2), .pass(pass2), .fail(fail2), .retry_count(retry2_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [31:0] slaveValue(input bit a);
    return a ? ((m_retries < bad_attempts) ? BAD_TS : GOOD_TS) : GOOD_ID;
  endfunction

  task automatic startCheck();
    m_checking = 1'b1;
    m_u = 0;
    m_retries = 0;
    m_pass = 1'b0;
    m_fail = 1'b0;
  endtask

  // Model update on each clock edge from the sampled inputs
  always @(posedge clock) begin
    if (reset) begin
      m_init = 1'b1;
      startCheck();
      m_id = '0; m_ts = '0; m_rdata = '0; m_valid = 1'b0;
      m_busy = 0; m_pending = 1'b0; m_addr = 1'b0;
    end else if (m_init) begin
      m_valid = 1'b0;
      if (m_checking) begin
        m_u++;
        if (m_u % P == L) m_id = slaveValue(1'b0);
        else if (m_u % P == 2 * L) m_ts = slaveValue(1'b1);
        else if (m_u % P == 2 * L + 1) begin
          if (m_id == GOOD_ID && m_ts == GOOD_TS) begin
            m_pass = 1'b1; m_checking = 1'b0;
          end else if (m_retries < MAXR) begin
            m_retries++;
          end else begin
            m_fail = 1'b1; m_checking = 1'b0;
          end
        end
      end else if (m_busy > 0) begin
        if (recheck) m_pending = 1'b1;
        m_busy--;
        if (m_busy == 0) begin
          m_rdata = m_pend_data;
          m_valid = 1'b1;
        end
      end else if (m_pending) begin
        m_pending = 1'b0;
        startCheck();
      end else if (cpu_read) begin
        m_addr = cpu_address;
        m_pend_data = slaveValue(cpu_address);
        m_busy = L;
        if (recheck) m_pending = 1'b1;
      end else if (recheck) begin
        startCheck();
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clock) begin
    if (m_init) begin
      checkOutput("m.waitrequest", cpu_waitrequest, (m_checking || m_busy > 0 || m_pending) ? 1 : 0);
      checkOutput("m.sid_address", sid_address,
                  m_checking ? (((m_u % P) >= L && (m_u % P) < 2 * L) ? 1 : 0) : ((m_busy > 0) ? m_addr : 0));
      checkOutput("m.done", done, m_pass | m_fail);
      checkOutput("m.pass", pass, m_pass);
      checkOutput("m.fail", fail, m_fail);
      checkOutput("m.retry_count", retry_count, m_retries);
      checkOutput("m.id_value", id_value, m_id);
      checkOutput("m.ts_value", ts_value, m_ts);
      checkOutput("m.readdatavalid", cpu_readdatavalid, m_valid);
      checkOutput("m.readdata", cpu_readdata, m_rdata);
    end
  end

  // Hold the current read request until it is accepted; ends just after the accepting edge
  task automatic waitAccept(output int n);
    n = 0;
    while (cpu_waitrequest !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
  endtask

  task automatic waitValid(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (cpu_readdatavalid !== 1'b1 && n < 20);
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  task automatic pulseRecheck();
    recheck = 1'b1;
    @(negedge clock);
    recheck = 1'b0;
  endtask

  // Directed scenario sequence
  initial begin
    int n;
    // Pass path after a 3-cycle reset
    applyStimulus(3);
    reset = 1'b0;
    checkOutput("reset waitrequest", cpu_waitrequest, 1);
    checkOutput("reset done", done, 0);
    checkOutput("reset id", id_value, 0);
    checkOutput("reset ts", ts_value, 0);
    checkOutput("reset sid", sid_address, 0);
    applyStimulus(4);
    checkOutput("edge4 done", done, 0);
    applyStimulus(1);
    checkOutput("edge5 done", done, 1);
    checkOutput("edge5 pass", pass, 1);
    checkOutput("edge5 fail", fail, 0);
    checkOutput("edge5 retry", retry_count, 0);
    checkOutput("edge5 id", id_value, 32'h0);
    checkOutput("edge5 ts", ts_value, 32'h5BA8CA7E);
    checkOutput("nots pass", pass2, 1);
    checkOutput("nots retry", retry2_count, 0);
    checkOutput("nots ts", ts2_value, 32'h5BA8CA7F);

    // Back-to-back CPU reads: address 1 then address 0
    cpu_read = 1'b1; cpu_address = 1'b1;
    waitAccept(n);
    checkOutput("rd1 accept wait", n, 0);
    checkOutput("rd1 waitreq busy", cpu_waitrequest, 1);
    cpu_address = 1'b0;
    waitValid(n);
    checkOutput("rd1 latency", n, 2);
    checkOutput("rd1 data", cpu_readdata, 32'h5BA8CA7E);
    waitAccept(n);
    checkOutput("rd0 accept wait", n, 0);
    cpu_read = 1'b0;
    waitValid(n);
    checkOutput("rd0 latency", n, 2);
    checkOutput("rd0 data", cpu_readdata, 32'h0);

    // Recheck together with a CPU read, then a read issued before done stalls
    cpu_read = 1'b1; cpu_address = 1'b1; recheck = 1'b1;
    waitAccept(n);
    cpu_read = 1'b0; recheck = 1'b0;
    waitValid(n);
    checkOutput("rc rd latency", n, 2);
    checkOutput("rc rd data", cpu_readdata, 32'h5BA8CA7E);
    checkOutput("rc done held", done, 1);
    checkOutput("rc pending waitreq", cpu_waitrequest, 1);
    cpu_read = 1'b1; cpu_address = 1'b0;
    applyStimulus(1);
    checkOutput("rc done cleared", done, 0);
    waitAccept(n);
    checkOutput("stall cycles", n, 5);
    cpu_read = 1'b0;
    checkOutput("stall pass", pass, 1);
    waitValid(n);
    checkOutput("stall rd data", cpu_readdata, 32'h0);

    // Persistent mismatch with a recheck pulse landing in the gap
    bad_attempts = 99;
    applyStimulus(1);
    pulseRecheck();
    applyStimulus(7);
    pulseRecheck();
    applyStimulus(35);
    checkOutput("mm u43 done", done, 0);
    checkOutput("mm u43 retry", retry_count, 3);
    applyStimulus(1);
    checkOutput("mm fail", fail, 1);
    checkOutput("mm pass", pass, 0);
    checkOutput("mm retry", retry_count, 3);
    checkOutput("mm ts", ts_value, 32'h5BA8CA7F);

    // Recovery on the third attempt
    bad_attempts = 2;
    pulseRecheck();
    applyStimulus(30);
    checkOutput("rv u30 done", done, 0);
    applyStimulus(1);
    checkOutput("rv pass", pass, 1);
    checkOutput("rv retry", retry_count, 2);
    checkOutput("rv fail", fail, 0);

    // Reset during the timestamp read
    bad_attempts = 0;
    pulseRecheck();
    applyStimulus(2);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("rst1 done", done, 0);
    checkOutput("rst1 ts", ts_value, 0);
    checkOutput("rst1 waitreq", cpu_waitrequest, 1);
    applyStimulus(5);
    checkOutput("rst1 rerun pass", pass, 1);

    // Reset during a CPU read: no valid pulse, check restarts
    cpu_read = 1'b1; cpu_address = 1'b1;
    waitAccept(n);
    cpu_read = 1'b0;
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("rst2 readdata", cpu_readdata, 0);
    checkOutput("rst2 done", done, 0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1);
      checkOutput("rst2 no valid", cpu_readdatavalid, 0);
    end
    checkOutput("rst2 rerun done", done, 1);

    applyStimulus(2);
    $display("test done: total=%0d bad=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
